eth_rxcmd_ctrl: RTL

Command sequencer behind the Ethernet RX header/command decoder. It latches the decoded command (24-bit address, 4-bit opcode) and buffers the following 32-bit payload words. At end of frame it either executes the command as transactions on a simple req/ack register bus or drops it. Frames with CRC error, address miss, buffer overflow or a bad opcode are dropped and counted.

---
 rtl/eth_rxcmd_ctrl_pkg.sv | 27 ++
 rtl/eth_rxcmd_ctrl_if.sv | 44 ++++
 rtl/eth_rxcmd_ctrl_fifo.sv | 54 +++++
 rtl/eth_rxcmd_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_rxcmd_ctrl_pkg.sv
// Shared opcodes, state encoding and address type for the Ethernet RX command sequencer.
package eth_cmd_pkg;

    typedef logic [23:0] addr_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_WR  = 4'h1;
    localparam logic [3:0] OP_RD  = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        WRITE,
        READ,
        DONE,
        DROP
    } state_t;

    // Adds 0..3 to a 16-bit event counter, sticking at all-ones.
    function automatic logic [15:0] satInc(input logic [15:0] value, input logic [1:0] amount);
        logic [16:0] sum;
        sum = {1'b0, value} + {15'd0, amount};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/eth_rxcmd_ctrl_if.sv
// Bundle of the decoder-side command/payload inputs, the register bus and the status outputs.
interface eth_rxcmd_ctrl_if;
    import eth_cmd_pkg::*;

    logic        RxValid;
    addr_t       cmd_addr;
    logic [3:0]  cmd_op;
    logic        fifo_wr_en;
    logic [31:0] fifo_data;
    logic        RxEndFrm;
    logic        CrcError;
    logic        AddressMiss;

    logic        bus_req;
    logic        bus_we;
    addr_t       bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        cmd_done;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    modport master (
        input  RxValid, cmd_addr, cmd_op, fifo_wr_en, fifo_data,
        input  RxEndFrm, CrcError, AddressMiss,
        input  bus_ack, bus_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        output rsp_valid, rsp_data, cmd_done, busy, drop_cnt, err_cnt
    );

    modport slave (
        output RxValid, cmd_addr, cmd_op, fifo_wr_en, fifo_data,
        output RxEndFrm, CrcError, AddressMiss,
        output bus_ack, bus_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        input  rsp_valid, rsp_data, cmd_done, busy, drop_cnt, err_cnt
    );

endinterface

// File: rtl/eth_rxcmd_ctrl_fifo.sv
// Synchronous show-ahead payload FIFO (DEPTH x 32) with flush; pushes while full are discarded.
module eth_cmd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [31:0]            data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [31:0]            data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            if (doPush && !doPop)      count_q <= count_q + (AW+1)'(1);
            else if (doPop && !doPush) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the entries between the pointers are meaningful.
    always_ff @(posedge clk_i) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/eth_rxcmd_ctrl.sv
// Command sequencer: latches a decoded RX command, buffers its payload and at end of
// frame replays it as req/ack register-bus transactions, or drops and counts it.
module eth_rxcmd_ctrl
    import eth_cmd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             MRxClk,
    input  logic             Reset_n,
    eth_rxcmd_ctrl_if.master ctrl
);
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    addr_t       addr_q, addr_d;
    logic [3:0]  op_q, op_d;
    addr_t       idx_q, idx_d;
    logic        ovf_q, ovf_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    addr_t       baddr_q, baddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] wait_q, wait_d;
    logic        rspValid_q, rspValid_d;
    logic [31:0] rspData_q, rspData_d;
    logic [15:0] dropCnt_q, dropCnt_d;
    logic [15:0] errCnt_q, errCnt_d;

    logic          push, pop, flush;
    logic [31:0]   fifoData;
    logic          fifoFull, fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          ackSeen, timedOut, dropInc;
    logic [1:0]    errInc;

    eth_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (MRxClk),
        .rst_ni  (Reset_n),
        .push_i  (push),
        .data_i  (ctrl.fifo_data),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign ackSeen  = req_q && ctrl.bus_ack;
    assign timedOut = req_q && !ctrl.bus_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        req_d      = req_q;
        we_d       = we_q;
        baddr_d    = baddr_q;
        wdata_d    = wdata_q;
        rspValid_d = 1'b0;
        rspData_d  = rspData_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        dropInc    = 1'b0;
        errInc     = (ctrl.RxValid && state_q != IDLE) ? 2'd1 : 2'd0;
        wait_d     = (req_q && !ctrl.bus_ack) ? wait_q + 16'd1 : 16'd0;

        case (state_q)
            IDLE: begin
                if (ctrl.RxValid) begin
                    addr_d  = ctrl.cmd_addr;
                    op_d    = ctrl.cmd_op;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // A word arriving with RxEndFrm is pushed first, so its overflow counts too.
                if (ctrl.fifo_wr_en) begin
                    if (fifoFull) ovf_d = 1'b1;
                    else          push  = 1'b1;
                end
                if (ctrl.RxEndFrm) begin
                    state_d = (ctrl.CrcError || ctrl.AddressMiss || ovf_d) ? DROP : CHECK;
                end
            end
            CHECK: begin
                case (op_q)
                    OP_WR: begin
                        if (!fifoEmpty) begin
                            state_d = WRITE;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            baddr_d = addr_q + idx_q;
                            wdata_d = fifoData;
                        end else begin
                            state_d = DONE;
                        end
                    end
                    OP_NOP: begin
                        state_d = DONE;
                        flush   = 1'b1;
                    end
                    OP_RD: begin
                        state_d = READ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        baddr_d = addr_q;
                        wdata_d = '0;
                        flush   = 1'b1;
                    end
                    default: begin
                        errInc  = errInc + 2'd1;
                        state_d = DROP;
                    end
                endcase
            end
            WRITE: begin
                // After each ack the request idles one cycle while the FIFO head advances.
                if (ackSeen) begin
                    pop   = 1'b1;
                    idx_d = idx_q + 24'd1;
                    req_d = 1'b0;
                    if (fifoCount == CW'(1)) state_d = DONE;
                end else if (timedOut) begin
                    req_d   = 1'b0;
                    errInc  = errInc + 2'd1;
                    state_d = DROP;
                end else if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    baddr_d = addr_q + idx_q;
                    wdata_d = fifoData;
                end
            end
            READ: begin
                if (ackSeen) begin
                    rspData_d  = ctrl.bus_rdata;
                    rspValid_d = 1'b1;
                    req_d      = 1'b0;
                    state_d    = DONE;
                end else if (timedOut) begin
                    req_d   = 1'b0;
                    errInc  = errInc + 2'd1;
                    state_d = DROP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DROP: begin
                flush   = 1'b1;
                dropInc = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dropCnt_d = satInc(dropCnt_q, {1'b0, dropInc});
        errCnt_d  = satInc(errCnt_q, errInc);
    end

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            op_q       <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            baddr_q    <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            dropCnt_q  <= '0;
            errCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            req_q      <= req_d;
            we_q       <= we_d;
            baddr_q    <= baddr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            dropCnt_q  <= dropCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign ctrl.bus_req   = req_q;
    assign ctrl.bus_we    = we_q;
    assign ctrl.bus_addr  = baddr_q;
    assign ctrl.bus_wdata = wdata_q;
    assign ctrl.rsp_valid = rspValid_q;
    assign ctrl.rsp_data  = rspData_q;
    assign ctrl.cmd_done  = (state_q == DONE);
    assign ctrl.busy      = (state_q != IDLE);
    assign ctrl.drop_cnt  = dropCnt_q;
    assign ctrl.err_cnt   = errCnt_q;

endmodule
